// File: rtl/bus_rx_fifo.sv
// Receive FIFO for a shared bus: accepts words addressed to MY_ID, presents them
// first-word-fall-through, and counts addressed words dropped while full.
module bus_rx_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int IDW   = 4,
    parameter int MY_ID = 0
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [N-1:0]               BusData,
    input  logic                       BusValid,
    input  logic [IDW-1:0]             BusDest,
    output logic                       BusBusy,
    output logic [N-1:0]               Dout,
    output logic                       DoutValid,
    input  logic                       DoutReady,
    output logic [$clog2(DEPTH):0]     Count,
    output logic [7:0]                 OvfCnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] rdptr;
    logic [AW-1:0] wrptr;
    logic [CW-1:0] count;
    logic [7:0]    ovf;
    logic          hit;
    logic          full;
    logic          push;
    logic          pop;

    always_comb begin
        hit  = BusValid && (BusDest == IDW'(MY_ID));
        full = (count == CW'(DEPTH));
        // Acceptance looks only at registered fullness, so a pop never frees room for the same cycle's word.
        push = hit && !full;
        pop  = (count != '0) && DoutReady;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rdptr <= '0;
            wrptr <= '0;
            count <= '0;
            ovf   <= '0;
        end else begin
            if (push)
                wrptr <= wrptr + 1'b1;
            if (pop)
                rdptr <= rdptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (hit && full && (ovf != '1))
                ovf <= ovf + 1'b1;
        end
    end

    // Storage carries no reset; its contents are meaningless while empty.
    always_ff @(posedge Clk) begin
        if (push && !Rst)
            mem[wrptr] <= BusData;
    end

    always_comb begin
        Dout      = mem[rdptr];
        DoutValid = (count != '0);
        BusBusy   = full;
        Count     = count;
        OvfCnt    = ovf;
    end

endmodule

// File: tb/tb_bus_rx_fifo.sv
// Directed bench for bus_rx_fifo: accepted words are queued as expected output and
// a separate monitor compares every word the consumer takes from Dout.
module tb_bus_rx_fifo;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] BusData;
    logic        BusValid;
    logic [3:0]  BusDest;
    logic        BusBusy;
    logic [31:0] Dout;
    logic        DoutValid;
    logic        DoutReady;
    logic [2:0]  Count;
    logic [7:0]  OvfCnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] expq[$];

    bus_rx_fifo #(.N(32), .DEPTH(4), .IDW(4), .MY_ID(0)) dut (
        .Clk(Clk), .Rst(Rst), .BusData(BusData), .BusValid(BusValid),
        .BusDest(BusDest), .BusBusy(BusBusy), .Dout(Dout), .DoutValid(DoutValid),
        .DoutReady(DoutReady), .Count(Count), .OvfCnt(OvfCnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs hold from just after one rising edge until just after the next.
    task automatic step(input logic v, input logic [3:0] d, input logic [31:0] data, input logic rdy);
        BusValid  = v;
        BusDest   = d;
        BusData   = data;
        DoutReady = rdy;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        step(1'b0, 4'd0, 32'd0, 1'b0);
        Rst = 1'b0;
        expq.delete();
    endtask

    // Monitor: a word leaves the FIFO whenever valid and ready meet outside reset.
    always @(negedge Clk) begin
        if (!Rst && DoutValid === 1'b1 && DoutReady === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", Dout);
            end else begin
                chk("pop_data", Dout, expq.pop_front());
            end
        end
    end

    initial begin
        Rst = 1'b1; BusValid = 1'b0; BusDest = '0; BusData = '0; DoutReady = 1'b0;
        @(posedge Clk); #1;
        do_reset();
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_valid", 32'(DoutValid), 32'd0);
        chk("rst_busy", 32'(BusBusy), 32'd0);
        chk("rst_ovf", 32'(OvfCnt), 32'd0);

        // Single addressed word falls through after one edge.
        expq.push_back(32'hA5A5_0001);
        step(1'b1, 4'd0, 32'hA5A5_0001, 1'b0);
        chk("first_valid", 32'(DoutValid), 32'd1);
        chk("first_dout", Dout, 32'hA5A5_0001);
        chk("first_count", 32'(Count), 32'd1);

        // Word for another address is ignored.
        step(1'b1, 4'd1, 32'hDEAD_BEEF, 1'b0);
        chk("miss_count", 32'(Count), 32'd1);
        chk("miss_dout", Dout, 32'hA5A5_0001);
        chk("miss_valid", 32'(DoutValid), 32'd1);
        chk("miss_ovf", 32'(OvfCnt), 32'd0);

        // Fill, then a hit while full and popping is still dropped.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            expq.push_back(32'(i));
            step(1'b1, 4'd0, 32'(i), 1'b0);
        end
        chk("full_busy", 32'(BusBusy), 32'd1);
        chk("full_count", 32'(Count), 32'd4);
        step(1'b1, 4'd0, 32'd5, 1'b1);
        chk("drop_count", 32'(Count), 32'd3);
        chk("drop_ovf", 32'(OvfCnt), 32'd1);
        chk("drop_busy", 32'(BusBusy), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 32'd0, 1'b1);
        chk("drain_count", 32'(Count), 32'd0);
        chk("drain_queue", 32'(expq.size()), 32'd0);

        // Streaming: push and pop every cycle, occupancy stays at one.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            expq.push_back(32'(i));
            step(1'b1, 4'd0, 32'(i), 1'b1);
            chk("stream_valid", 32'(DoutValid), 32'd1);
            chk("stream_dout", Dout, 32'(i));
            chk("stream_count", 32'(Count), 32'd1);
        end
        step(1'b0, 4'd0, 32'd0, 1'b1);
        chk("stream_empty", 32'(Count), 32'd0);
        chk("stream_ovf", 32'(OvfCnt), 32'd0);

        // Overflow counter saturates and is cleared only by reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            expq.push_back(32'(32'h100 + i));
            step(1'b1, 4'd0, 32'(32'h100 + i), 1'b0);
        end
        for (int i = 0; i < 300; i++) step(1'b1, 4'd0, 32'(32'h200 + i), 1'b0);
        chk("sat_ovf", 32'(OvfCnt), 32'd255);
        chk("sat_count", 32'(Count), 32'd4);
        chk("sat_dout", Dout, 32'h100);
        do_reset();
        chk("sat_rst_count", 32'(Count), 32'd0);
        chk("sat_rst_ovf", 32'(OvfCnt), 32'd0);
        chk("sat_rst_valid", 32'(DoutValid), 32'd0);

        // Pointer wrap keeps order.
        for (int i = 11; i <= 13; i++) begin
            expq.push_back(32'(i));
            step(1'b1, 4'd0, 32'(i), 1'b0);
        end
        step(1'b0, 4'd0, 32'd0, 1'b1);
        step(1'b0, 4'd0, 32'd0, 1'b1);
        for (int i = 14; i <= 16; i++) begin
            expq.push_back(32'(i));
            step(1'b1, 4'd0, 32'(i), 1'b0);
        end
        chk("wrap_count", 32'(Count), 32'd4);
        chk("wrap_head", Dout, 32'd13);
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 32'd0, 1'b1);
        chk("wrap_empty", 32'(Count), 32'd0);
        chk("wrap_queue", 32'(expq.size()), 32'd0);

        // Reset wins over a simultaneous push and pop.
        expq.push_back(32'd21);
        step(1'b1, 4'd0, 32'd21, 1'b0);
        expq.push_back(32'd22);
        step(1'b1, 4'd0, 32'd22, 1'b0);
        Rst = 1'b1;
        step(1'b1, 4'd0, 32'd99, 1'b1);
        Rst = 1'b0;
        expq.delete();
        chk("rstpp_count", 32'(Count), 32'd0);
        chk("rstpp_valid", 32'(DoutValid), 32'd0);
        chk("rstpp_busy", 32'(BusBusy), 32'd0);
        step(1'b0, 4'd0, 32'd0, 1'b1);
        chk("rstpp_hold", 32'(Count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_rx_fifo.md
BUS_RX_FIFO -- requirements
Module: bus_rx_fifo

Interface
REQ-001 Parameter N, default 32: bus data width in bits.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-003 Parameter IDW, default 4: destination-ID width in bits.
REQ-004 Parameter MY_ID, default 0: this receiver's bus address.
REQ-005 Clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Rst  input  1  reset, synchronous, active-high.
REQ-007 BusData  input  N  shared-bus data, driven by the enabled tri-state sender.
REQ-008 BusValid  input  1  sender strobe; BusData and BusDest are valid this cycle.
REQ-009 BusDest  input  IDW  destination ID of the current bus word.
REQ-010 BusBusy  output  1  back-pressure to senders; high while the FIFO is full.
REQ-011 Dout  output  N  head-of-FIFO word.
REQ-012 DoutValid  output  1  Dout holds a valid word.
REQ-013 DoutReady  input  1  consumer accepts Dout this cycle.
REQ-014 Count  output  clog2(DEPTH)+1  current occupancy.
REQ-015 OvfCnt  output  8  count of dropped addressed words, saturating.

Function
REQ-016 Hit is BusValid=1 and BusDest=MY_ID; all non-hit cycles are ignored.
REQ-017 Push occurs when Hit=1 and Count<DEPTH; BusData is written at the write pointer on that edge.
REQ-018 Pop occurs when DoutValid=1 and DoutReady=1; the read pointer advances on that edge.
REQ-019 First-word-fall-through: Dout = entry at read pointer; DoutValid = (Count!=0); no read latency.
REQ-020 Push-to-output latency is 1 cycle: a word pushed at edge k is on Dout with DoutValid=1 after edge k if the FIFO was empty.
REQ-021 BusBusy is high exactly when Count=DEPTH, decoded from registered state only, with no combinational path from any input.
REQ-022 Hit with Count=DEPTH is a drop: nothing is written and OvfCnt increments.
REQ-023 The drop rule holds even if a pop occurs in the same cycle, so a full FIFO never accepts a word in the cycle it pops.
REQ-024 OvfCnt saturates at 255 and holds until reset.
REQ-025 Simultaneous push and pop with 0<Count<DEPTH: both pointers advance and Count is unchanged.
REQ-026 Push alone: Count+1. Pop alone: Count-1.
REQ-027 Pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH with no gap.
REQ-028 Word order at Dout equals accepted order at the bus, including across pointer wrap.
REQ-029 DoutReady while DoutValid=0 has no effect.
REQ-030 Dout and DoutValid are stable while DoutValid=1 and DoutReady=0.

Reset
REQ-031 With Rst=1 at a rising edge: read and write pointers, Count and OvfCnt go to 0; DoutValid=0 and BusBusy=0 from the next cycle.
REQ-032 Rst has priority over any simultaneous push or pop; FIFO contents are discarded.
REQ-033 Rst asserted mid-operation returns the block to the empty state in one edge, with no partial transfer.
REQ-034 Memory array contents need no reset; Dout value is don't-care while DoutValid=0.

Verification
REQ-035 Reset, then Hit with BusData=0xA5A5_0001 and DoutReady=0 -> next cycle DoutValid=1, Dout=0xA5A5_0001, Count=1.
REQ-036 BusValid=1, BusDest=MY_ID+1, BusData=0xDEAD_BEEF -> Count, Dout, DoutValid and OvfCnt unchanged.
REQ-037 Push 1,2,3,4 with DoutReady=0 -> BusBusy=1, Count=4; 5th Hit with DoutReady=1 -> word 1 popped, 5 dropped, Count=3, OvfCnt=1, BusBusy=0.
REQ-038 Continuous Hit plus DoutReady=1 for 10 words 0..9 from empty -> Dout sequence 0..9, each one cycle after its push, Count stays at 1 or less, OvfCnt=0.
REQ-039 Fill the FIFO, then Hit for 300 cycles with no pops -> OvfCnt=255 held; Rst pulse -> Count=0, OvfCnt=0, DoutValid=0.
REQ-040 Fill 3, pop 2, push 3 more (pointer wrap) -> pop order preserved; Rst asserted with push and pop in the same cycle -> empty state next cycle.
